iob_eth_tx_mii: RTL
===================

// Module: iob_eth_tx_mii
// PURPOSE
//  MII transmit framer for the iob_eth core; it drives the MAC TX_CLK-domain egress path.
//  On start, it serialises one Ethernet frame onto TX_DATA/TX_EN. The frame is preamble, SFD,
//  nbytes read from the TX frame buffer (dest MAC, src MAC, type, payload), optional zero pad,
//  and a CRC-32 FCS. It then enforces the inter-frame gap.
//  It is the producer counterpart of the iob_eth MII receive path; the TX nibble stream must be
//  accepted unchanged by that receiver when looped back.
// PARAMETERS
//  BUF_ADDR_W    11  TX buffer byte address width; nbytes_i width; max frame data 2^BUF_ADDR_W-1 bytes
//  PREAMBLE_LEN  7   preamble bytes (0x55) before SFD
//  IFG_BYTES     12  inter-frame gap, bytes of TX_EN=0 after FCS
//  MIN_DATA      60  minimum header+payload bytes; shorter frames are zero-padded; 0 disables padding
// PORTS
//  clk         in   1           TX_CLK domain clock; the only clock
//  rst_n       in   1           synchronous reset, active-low
//  start_i     in   1           frame request; sampled only while ready_o=1
//  nbytes_i    in   BUF_ADDR_W  header+payload byte count; latched on accept
//  ready_o     in/o out 1       1 = IDLE, can accept start_i
//  done_o      out  1           1-cycle pulse when the frame and IFG are complete
//  buf_addr_o  out  BUF_ADDR_W  TX buffer read address (byte)
//  buf_data_i  in   8           TX buffer read data; synchronous read, 1-cycle latency
//  TX_EN       out  1           MII transmit enable
//  TX_DATA     out  4           MII transmit nibble, low nibble of each byte first
// BEHAVIOUR
//  Reset
//   - rst_n=0 at a clk edge: state=IDLE; TX_EN=0; TX_DATA=0; done_o=0; buf_addr_o=0; CRC=0xFFFFFFFF.
//   - ready_o=1 from the first cycle after reset.
//   - Mid-frame reset aborts the frame immediately: no done_o, no FCS emitted.
//  States: IDLE -> PRE -> SFD -> DATA -> [PAD] -> FCS -> IFG -> IDLE. Each byte takes 2 cycles (nibble phase 0/1).
//  IDLE
//   - ready_o=1.
//   - If start_i=1 and nbytes_i!=0, latch nbytes_i, init CRC, go to PRE; TX_EN=1 on the next cycle.
//   - start_i with nbytes_i=0 is ignored: stay IDLE, no done_o.
//  Busy states: ready_o=0; start_i is ignored.
//  PRE: PREAMBLE_LEN bytes of 0x55 (nibbles 5,5).
//  SFD: byte 0xD5 (nibbles 5,D).
//  DATA
//   - Bytes 0..n-1 from the buffer.
//   - buf_addr_o=k is driven in the phase-1 cycle of the preceding byte (SFD for k=0).
//   - buf_data_i is registered in the phase-0 cycle of byte k.
//   - buf_addr_o never exceeds n-1 and holds its value outside DATA.
//  PAD: entered only if MIN_DATA!=0 and n<MIN_DATA; emits MIN_DATA-n bytes of 0x00.
//  CRC rules
//   - The CRC covers DATA and PAD bytes only.
//   - Reflected polynomial 0xEDB88320, updated one byte per phase-1 cycle.
//  FCS
//   - Emits ~CRC as 4 bytes, LSB byte first, low nibble first.
//   - TX_EN drops in the cycle after the last FCS nibble.
//  IFG: 2*IFG_BYTES cycles with TX_EN=0 and TX_DATA=0.
//  End of frame
//   - done_o=1 in the first IDLE cycle; that same cycle start_i may be accepted.
//   - Minimum TX_EN-low gap between frames = 2*IFG_BYTES+1 cycles.
//  TX_EN-high length = 2*(PREAMBLE_LEN+1+max(n,MIN_DATA)+4) cycles, contiguous, no gaps.
//  Counters: byte counter is BUF_ADDR_W+1 bits wide, so there is no wrap at n=2^BUF_ADDR_W-1.
// STRUCTURE
//  - iob_eth.vh holds ETH_PREAMBLE (0x55), ETH_SFD (0xD5), PREAMBLE_LEN, ETH_CRC_POLY (0xEDB88320),
//    ETH_CRC_INIT (0xFFFFFFFF) and IFG_BYTES; the state encoding is localparam.
//  - Sub-module iob_eth_crc32: combinational byte-wise CRC-32 next-state function, shared with the
//    RX checker.
//  - This block holds the FSM, byte/nibble counters and output registers.
// TESTING
//  1. PREAMBLE_LEN=7, MIN_DATA=0, buffer "123456789", nbytes=9 -> TX_EN high exactly 42 cycles.
//     Nibbles: 14x5, 5, D, 1,3,2,3,...,9,3, then FCS 6,2,9,3,4,F,B,C (bytes 26 39 F4 CB); then done_o after 24 idle cycles.
//  2. MIN_DATA=60, nbytes=14 (header only) -> 46 pad bytes 0x00; TX_EN high 144 cycles.
//     Loopback into the iob_eth RX accepts the frame (status bit1 set, CRC ok).
//  3. start_i held at 1, two 64-byte frames -> TX_EN low gap exactly 25 cycles; two done_o pulses.
//     The second FCS is correct (CRC reinitialised).
//  4. start_i with nbytes=0 -> nothing happens: ready_o stays 1, TX_EN 0, no done_o.
//     start_i pulsed mid-DATA -> ignored, frame unchanged.
//  5. rst_n=0 for 1 cycle at byte 5 of DATA -> next cycle TX_EN=0, ready_o=1, no done_o.
//     A following frame's FCS matches the reference CRC.
//  6. nbytes=2^BUF_ADDR_W-1 -> all addresses 0..2046 read once in order, no wrap, correct FCS.

Source files
------------

// File: rtl/iob_eth_pkg.sv
// Shared constants and state encoding for the iob_eth MII transmit/receive paths.
package iob_eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE     = 8'h55;
    localparam logic [7:0]  ETH_SFD          = 8'hD5;
    localparam int          ETH_PREAMBLE_LEN = 7;
    localparam int          ETH_IFG_BYTES    = 12;
    localparam logic [31:0] ETH_CRC_POLY     = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC_INIT     = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } tx_state_t;

endpackage

// File: rtl/iob_eth_crc32.sv
// Byte-wise reflected CRC-32 next-state function; shared by the TX framer and RX checker.
module iob_eth_crc32
    import iob_eth_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] next_crc
);

    always_comb begin
        next_crc = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            next_crc = next_crc[0] ? ((next_crc >> 1) ^ ETH_CRC_POLY) : (next_crc >> 1);
        end
    end

endmodule

// File: rtl/iob_eth_tx_mii.sv
// MII transmit framer: preamble, SFD, buffered frame data, zero pad, FCS, then inter-frame gap.
module iob_eth_tx_mii
    import iob_eth_pkg::*;
#(
    parameter int BUF_ADDR_W   = 11,
    parameter int PREAMBLE_LEN = ETH_PREAMBLE_LEN,
    parameter int IFG_BYTES    = ETH_IFG_BYTES,
    parameter int MIN_DATA     = 60
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [BUF_ADDR_W-1:0] nbytes_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [BUF_ADDR_W-1:0] buf_addr_o,
    input  logic [7:0]            buf_data_i,
    output logic                  TX_EN,
    output logic [3:0]            TX_DATA
);

    // One extra bit so the counter never wraps at the largest frame.
    localparam int CW = BUF_ADDR_W + 1;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t ONE      = cnt_t'(1);
    localparam cnt_t PRE_LAST = cnt_t'(PREAMBLE_LEN - 1);
    localparam cnt_t PAD_LAST = cnt_t'(MIN_DATA - 1);
    localparam cnt_t FCS_LAST = cnt_t'(3);
    localparam cnt_t IFG_LAST = cnt_t'(IFG_BYTES - 1);
    localparam cnt_t MIN_N    = cnt_t'(MIN_DATA);

    tx_state_t             state, next_state;
    logic                  phase;
    cnt_t                  cnt;
    cnt_t                  cnt_inc;
    cnt_t                  n_ext;
    logic [BUF_ADDR_W-1:0] nbytes_q;
    logic [31:0]           crc;
    logic [31:0]           crc_next;
    logic [31:0]           fcs;
    logic [7:0]            crc_byte;
    logic [7:0]            data_q;
    logic [7:0]            cur_byte;
    logic [BUF_ADDR_W-1:0] addr_q;
    logic                  done_q;
    logic                  accept;
    logic                  last_data;
    logic                  pad_needed;

    assign n_ext      = {1'b0, nbytes_q};
    assign cnt_inc    = cnt + ONE;
    assign last_data  = (cnt == n_ext - ONE);
    assign pad_needed = (MIN_DATA != 0) && (n_ext < MIN_N);
    assign accept     = (state == ST_IDLE) && start_i && (nbytes_i != '0);
    assign fcs        = ~crc;
    assign crc_byte   = (state == ST_DATA) ? data_q : 8'h00;
    assign buf_addr_o = addr_q;
    assign done_o     = done_q;

    iob_eth_crc32 u_crc (
        .crc      (crc),
        .data     (crc_byte),
        .next_crc (crc_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept) next_state = ST_PRE;
            ST_PRE:  if (phase && cnt == PRE_LAST) next_state = ST_SFD;
            ST_SFD:  if (phase) next_state = ST_DATA;
            ST_DATA: if (phase && last_data) next_state = pad_needed ? ST_PAD : ST_FCS;
            ST_PAD:  if (phase && cnt == PAD_LAST) next_state = ST_FCS;
            ST_FCS:  if (phase && cnt == FCS_LAST) next_state = ST_IFG;
            ST_IFG:  if (phase && cnt == IFG_LAST) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Phase 0 of a data byte streams the buffer output directly; phase 1 uses the captured copy.
    always_comb begin
        ready_o  = (state == ST_IDLE);
        TX_EN    = 1'b0;
        cur_byte = 8'h00;
        case (state)
            ST_PRE:  begin TX_EN = 1'b1; cur_byte = ETH_PREAMBLE; end
            ST_SFD:  begin TX_EN = 1'b1; cur_byte = ETH_SFD; end
            ST_DATA: begin TX_EN = 1'b1; cur_byte = phase ? data_q : buf_data_i; end
            ST_PAD:  TX_EN = 1'b1;
            ST_FCS:  begin TX_EN = 1'b1; cur_byte = fcs[{cnt[1:0], 3'b000} +: 8]; end
            default: ;
        endcase
        TX_DATA = phase ? cur_byte[7:4] : cur_byte[3:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase    <= 1'b0;
            cnt      <= '0;
            nbytes_q <= '0;
            crc      <= ETH_CRC_INIT;
            data_q   <= 8'h00;
            addr_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            phase  <= (state != ST_IDLE) && !phase;
            done_q <= (state == ST_IFG) && phase && (cnt == IFG_LAST);

            // Padding continues counting from n so it ends at MIN_DATA-1.
            if (next_state != state)
                cnt <= (state == ST_DATA && next_state == ST_PAD) ? cnt_inc : '0;
            else if (phase)
                cnt <= cnt_inc;

            if (accept) begin
                nbytes_q <= nbytes_i;
                crc      <= ETH_CRC_INIT;
            end else if (phase && (state == ST_DATA || state == ST_PAD)) begin
                crc <= crc_next;
            end

            if (state == ST_DATA && !phase)
                data_q <= buf_data_i;

            // Address for byte k is presented one cycle ahead of its phase-0 cycle.
            if (state == ST_SFD && !phase)
                addr_q <= '0;
            else if (state == ST_DATA && !phase && !last_data)
                addr_q <= cnt_inc[BUF_ADDR_W-1:0];
        end
    end

endmodule
